// File: rtl/read_burst_collector_if.sv
// -----------------------------------------------------------------------------
// read_burst_collector_if
// Bundles the scheduler issue port, the DRAM DQ bus and the MSHR-side line
// return port of read_burst_collector.
//   master : scheduler / DRAM / consumer side (drives issue, dq, line_ready)
//   slave  : collector side (drives issue_ready, line_*, outstanding)
// Signals:
//   issue_valid_in / issue_col_in / issue_tag_in / issue_ready_out : READ issue
//   dq_in                                                         : DRAM data
//   line_valid_out / line_ready_in / line_data_out / line_tag_out : line return
//   outstanding_out                                               : in-flight count
// -----------------------------------------------------------------------------
interface read_burst_collector_if #(
    parameter int unsigned BURST_LEN       = 8,
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned COL_BITS        = 4,
    parameter int unsigned TAG_BITS        = 4,
    parameter int unsigned MAX_OUTSTANDING = 8
);
    localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);

    logic                            issue_valid_in;
    logic [COL_BITS-1:0]             issue_col_in;
    logic [TAG_BITS-1:0]             issue_tag_in;
    logic                            issue_ready_out;
    logic [DATA_WIDTH-1:0]           dq_in;
    logic                            line_valid_out;
    logic                            line_ready_in;
    logic [BURST_LEN*DATA_WIDTH-1:0] line_data_out;
    logic [TAG_BITS-1:0]             line_tag_out;
    logic [OutW-1:0]                 outstanding_out;

    modport master (
        output issue_valid_in, issue_col_in, issue_tag_in, dq_in, line_ready_in,
        input  issue_ready_out, line_valid_out, line_data_out, line_tag_out, outstanding_out
    );

    modport slave (
        input  issue_valid_in, issue_col_in, issue_tag_in, dq_in, line_ready_in,
        output issue_ready_out, line_valid_out, line_data_out, line_tag_out, outstanding_out
    );
endinterface

// File: rtl/read_burst_collector.sv
// -----------------------------------------------------------------------------
// read_burst_collector
// Tracks issued DRAM READs, samples each burst off DQ exactly CAS_LATENCY
// cycles after issue, reorders beats critical-word-first into a full line and
// returns tagged lines in issue order over valid/ready. A credit check on
// issue guarantees a FIFO slot for every in-flight line, since DQ cannot stall.
// Ports:
//   clk_in  : clock, rising edge
//   rst_in  : asynchronous active-high reset
//   io_bus  : read_burst_collector_if.slave (issue, dq, line return, outstanding)
// -----------------------------------------------------------------------------
module read_burst_collector #(
    parameter int unsigned CAS_LATENCY     = 22,
    parameter int unsigned BURST_LEN       = 8,
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned COL_BITS        = 4,
    parameter int unsigned TAG_BITS        = 4,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned OUT_DEPTH       = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    read_burst_collector_if.slave io_bus
);
    localparam int unsigned IdxW  = $clog2(BURST_LEN);
    localparam int unsigned LineW = BURST_LEN * DATA_WIDTH;
    localparam int unsigned PtrW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned FPtrW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int unsigned LatW  = $clog2(CAS_LATENCY);
    localparam int unsigned OutW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned FCntW = $clog2(OUT_DEPTH + 1);
    localparam int unsigned SumW  = $clog2(MAX_OUTSTANDING + OUT_DEPTH + 1);

    // In-flight entries, circular in issue order; each has its own countdown.
    logic [LatW-1:0]       r_ent_lat [MAX_OUTSTANDING];
    logic [IdxW-1:0]       r_ent_col [MAX_OUTSTANDING];
    logic [TAG_BITS-1:0]   r_ent_tag [MAX_OUTSTANDING];
    logic [PtrW-1:0]       r_ent_wr;
    logic [PtrW-1:0]       r_ent_rd;
    logic [OutW-1:0]       r_inflight;
    logic [IdxW-1:0]       r_space_cnt;
    logic [IdxW-1:0]       r_beat;
    logic [DATA_WIDTH-1:0] r_asm [BURST_LEN];

    logic [LineW-1:0]      r_fifo_data [OUT_DEPTH];
    logic [TAG_BITS-1:0]   r_fifo_tag [OUT_DEPTH];
    logic [FPtrW-1:0]      r_fifo_wr;
    logic [FPtrW-1:0]      r_fifo_rd;
    logic [FCntW-1:0]      r_fifo_cnt;
    logic [LineW-1:0]      r_last_data;
    logic [TAG_BITS-1:0]   r_last_tag;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_capture;
    logic                  w_retire;
    logic                  w_valid;
    logic                  w_pop;
    logic [IdxW-1:0]       w_word_idx;
    logic [LineW-1:0]      w_line;
    logic [SumW-1:0]       w_credit_used;
    logic                  w_unused_col;

    assign w_unused_col  = ^io_bus.issue_col_in;  // upper column bits do not affect order
    assign w_credit_used = SumW'(r_inflight) + SumW'(r_fifo_cnt);
    assign w_ready       = !rst_in && (r_space_cnt == '0)
                           && (w_credit_used < SumW'(OUT_DEPTH))
                           && (r_inflight < OutW'(MAX_OUTSTANDING));
    assign w_accept      = io_bus.issue_valid_in && w_ready;

    // Bus spacing keeps bursts disjoint, so only the head entry can be on DQ.
    assign w_capture     = (r_inflight != '0) && (r_ent_lat[r_ent_rd] == '0);
    assign w_retire      = w_capture && (r_beat == IdxW'(BURST_LEN - 1));
    assign w_word_idx    = r_ent_col[r_ent_rd] + r_beat;
    assign w_valid       = (r_fifo_cnt != '0);
    assign w_pop         = w_valid && io_bus.line_ready_in;

    // Completed line including the beat being sampled at this edge.
    always_comb begin
        w_line = '0;
        for (int i = 0; i < BURST_LEN; i++) begin
            w_line[i*DATA_WIDTH +: DATA_WIDTH] = (w_word_idx == IdxW'(i)) ? io_bus.dq_in
                                                                          : r_asm[i];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_space_cnt <= '0;
            r_ent_wr    <= '0;
            r_ent_rd    <= '0;
            r_inflight  <= '0;
            r_beat      <= '0;
            r_fifo_wr   <= '0;
            r_fifo_rd   <= '0;
            r_fifo_cnt  <= '0;
            r_last_data <= '0;
            r_last_tag  <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                r_ent_lat[i] <= '0;
                r_ent_col[i] <= '0;
                r_ent_tag[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_space_cnt <= IdxW'(BURST_LEN - 1);
            end else if (r_space_cnt != '0) begin
                r_space_cnt <= r_space_cnt - 1'b1;
            end

            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (r_ent_lat[i] != '0) begin
                    r_ent_lat[i] <= r_ent_lat[i] - 1'b1;
                end
            end
            if (w_accept) begin
                r_ent_lat[r_ent_wr] <= LatW'(CAS_LATENCY - 1);
                r_ent_col[r_ent_wr] <= io_bus.issue_col_in[IdxW-1:0];
                r_ent_tag[r_ent_wr] <= io_bus.issue_tag_in;
                r_ent_wr <= (r_ent_wr == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : r_ent_wr + 1'b1;
            end

            // Beat counter wraps to zero on the retiring beat.
            if (w_capture) begin
                r_beat <= r_beat + 1'b1;
            end
            if (w_retire) begin
                r_ent_rd  <= (r_ent_rd == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : r_ent_rd + 1'b1;
                r_fifo_wr <= (r_fifo_wr == FPtrW'(OUT_DEPTH - 1)) ? '0 : r_fifo_wr + 1'b1;
            end

            unique case ({w_accept, w_retire})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase

            if (w_pop) begin
                r_fifo_rd   <= (r_fifo_rd == FPtrW'(OUT_DEPTH - 1)) ? '0 : r_fifo_rd + 1'b1;
                r_last_data <= r_fifo_data[r_fifo_rd];
                r_last_tag  <= r_fifo_tag[r_fifo_rd];
            end

            unique case ({w_retire, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // Storage only; validity is tracked by the reset-cleared counters above.
    always_ff @(posedge clk_in) begin
        if (w_capture) begin
            r_asm[w_word_idx] <= io_bus.dq_in;
        end
        if (w_retire) begin
            r_fifo_data[r_fifo_wr] <= w_line;
            r_fifo_tag[r_fifo_wr]  <= r_ent_tag[r_ent_rd];
        end
    end

    assign io_bus.issue_ready_out = w_ready;
    assign io_bus.line_valid_out  = w_valid;
    assign io_bus.line_data_out   = w_valid ? r_fifo_data[r_fifo_rd] : r_last_data;
    assign io_bus.line_tag_out    = w_valid ? r_fifo_tag[r_fifo_rd] : r_last_tag;
    assign io_bus.outstanding_out = r_inflight;
endmodule

// File: doc/read_burst_collector.md
Name: read_burst_collector

Overview:
- Parametrised successor to the DIMM read-return path in the memory controller.
- Tracks READ commands issued by the scheduler and samples each data burst off the DQ bus exactly CAS_LATENCY cycles after issue.
- Reorders beats critical-word-first into a full line and delivers tagged lines to the MSHR side over a valid/ready interface.
- Uses a credit rule so the DRAM bus, which cannot be stalled, never overruns the output buffer.

Parameters:
- CAS_LATENCY, 22: cycles from accepted issue to first data beat (≥2).
- BURST_LEN, 8: beats per burst; power of two, ≥2.
- DATA_WIDTH, 64: DQ bus width in bits.
- COL_BITS, 4: column address width; must be ≥ log2(BURST_LEN).
- TAG_BITS, 4: requester tag width.
- MAX_OUTSTANDING, 8: maximum in-flight reads (issued, last beat not yet sampled).
- OUT_DEPTH, 8: completed-line output FIFO depth; must be ≥ MAX_OUTSTANDING.

Ports:
- clk_in  in  1  clock; all sampling on rising edge.
- rst_in  in  1  asynchronous, active-high reset.
- issue_valid_in  in  1  scheduler is driving a READ this cycle.
- issue_col_in  in  COL_BITS  column of the READ.
- issue_tag_in  in  TAG_BITS  requester tag.
- issue_ready_out  out  1  a READ may be issued this cycle.
- dq_in  in  DATA_WIDTH  DRAM data bus.
- line_valid_out  out  1  completed line available.
- line_ready_in  in  1  consumer accepts the line.
- line_data_out  out  BURST_LEN*DATA_WIDTH  word i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- line_tag_out  out  TAG_BITS  tag of the presented line.
- outstanding_out  out  $clog2(MAX_OUTSTANDING+1)  current in-flight count.

Behaviour:
- Reset (rst_in asserted, asynchronous): all in-flight entries and FIFO contents are discarded, including partial lines. Output values while in reset:
  - issue_ready_out = 0.
  - line_valid_out = 0.
  - line_data_out = 0.
  - line_tag_out = 0.
  - outstanding_out = 0.
  - The spacing counter clears.
- Reset release: issue_ready_out is combinational and may assert in the first cycle after release.
- Issue handshake:
  - A READ is accepted in cycle T when issue_valid_in && issue_ready_out.
  - issue_valid_in without ready is ignored, not queued; the scheduler must retry.
- issue_ready_out = !spacing_busy && (inflight + fifo_count) < OUT_DEPTH && inflight < MAX_OUTSTANDING.
  - fifo_count counts lines held in the output FIFO.
  - The credit check guarantees a slot for every in-flight line regardless of line_ready_in.
- Bus spacing: after an acceptance in cycle T, spacing_busy holds for cycles T+1 .. T+BURST_LEN-1. Bursts therefore never overlap on DQ; back-to-back bursts with zero gap are allowed.
- Beat capture:
  - Beat k (k = 0..BURST_LEN-1) is dq_in sampled at the rising edge ending cycle T+CAS_LATENCY+k.
  - It is written to word index (issue_col_in[log2(BURST_LEN)-1:0] + k) mod BURST_LEN, wrapping critical-word-first.
  - Upper column bits are ignored.
- In-flight tracking:
  - Entries are kept in issue order; each entry carries its own latency countdown.
  - No global timestamp is used, so there is no counter wrap hazard.
  - The entry retires at the edge that samples its last beat; outstanding_out decrements in cycle T+CAS_LATENCY+BURST_LEN.
- Output latency: the line is pushed to the output FIFO at the retire edge. line_valid_out is first high in cycle T+CAS_LATENCY+BURST_LEN.
- Output handshake:
  - The FIFO head is presented on line_data_out/line_tag_out, and holds stable while line_valid_out && !line_ready_in.
  - The head pops on line_valid_out && line_ready_in.
  - When the FIFO is empty, line_data_out/line_tag_out hold their last value; they are don't-care while line_valid_out = 0.
  - A push and a pop in the same cycle are both honoured, and fifo_count is unchanged.
  - A line pushed into an empty FIFO appears the cycle after the push; there is no same-cycle bypass.
- Simultaneous events in one cycle are all legal together:
  - an acceptance, a retire, a pop, and the credit update.
  - issue_ready_out is computed from pre-edge counts, so a same-cycle pop does not free a credit until the next cycle.
- Lines are returned strictly in issue order.

Test Plan:
- Single read: issue col=0 tag=3 in cycle 10, dq_in = 0x100+k during beat k, line_ready_in=1 -> line_valid_out high in cycle 40 only; word i = 0x100+i; tag = 3; outstanding_out 1 during cycles 11..39, then 0.
- Wrap: issue col=5 (col=0xD also) -> word5=0x100, word7=0x102, word0=0x103, word4=0x107; both issues give identical lines.
- Spacing: issue_valid_in held high from cycle 0 -> accepts in cycles 0, 8, 16; issue_ready_out low in cycles 1-7 and 9-15; lines valid in cycles 30, 38, 46 with contiguous beats.
- Backpressure: line_ready_in=0, continuous issue -> exactly 8 accepts (OUT_DEPTH), then issue_ready_out stays 0. Raise line_ready_in -> lines pop in order, one per cycle; issue_ready_out reasserts the cycle after the first pop.
- Reset mid-burst: assert rst_in in cycle T+CAS_LATENCY+3 -> all outputs 0 immediately; no line is ever produced for that tag. A fresh issue after release completes normally with correct data.
- Parameter sweep (CAS_LATENCY=5, BURST_LEN=4, DATA_WIDTH=32, MAX_OUTSTANDING=2, OUT_DEPTH=2): issue col=2 in cycle 0 -> line valid in cycle 9 with word2=beat0 and word1=beat3. A third issue is refused until the first line pops.
